// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM state encoding, default sizing
// and a byte-lane helper for the packed request data bus.
package uart_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUSY_TIMEOUT = 15;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DATA_W           = 8;
  localparam int ID_W             = 3;
  localparam int MAX_REQ          = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Extract byte lane 'id' from a request data bus zero-extended to MAX_REQ lanes.
  function automatic logic [DATA_W-1:0] lane_byte(input logic [DATA_W*MAX_REQ-1:0] bus,
                                                  input logic [ID_W-1:0]            id);
    return DATA_W'(bus >> {id, 3'b000});
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requester found searching
// from last+1 (mod NUM_REQ) wins.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  int   cand_s;
  logic hit_s;

  // Scan from the farthest candidate back to the nearest so the nearest one is kept.
  always_comb begin
    winner = {ID_W{1'b0}};
    valid  = 1'b0;
    cand_s = 0;
    hit_s  = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_s = (int'(last) + i) % NUM_REQ;
      hit_s  = ((req & (NUM_REQ'(1'b1) << cand_s)) != {NUM_REQ{1'b0}});
      winner = hit_s ? ID_W'(cand_s) : winner;
      valid  = valid | hit_s;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to let a requester keep the grant for up to MAX_BURST bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    arb_en,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_data,
  input  logic [NUM_REQ-1:0]      req_lock,
  output logic [NUM_REQ-1:0]      ack,
  output logic [ID_W-1:0]         grant_id,
  output logic                    err,
  output logic                    busy,
  output logic [DATA_W-1:0]       Tx_DATA,
  output logic                    Tx_WR,
  output logic                    Tx_EN,
  input  logic                    Tx_BUSY
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e              state_r;
  logic [ID_W-1:0]         last_r;
  logic [ID_W-1:0]         grant_r;
  logic [NUM_REQ-1:0]      ack_r;
  logic [DATA_W-1:0]       data_r;
  logic                    wr_r;
  logic                    en_r;
  logic                    err_r;
  logic [CNT_W-1:0]        tmo_cnt_r;

  logic [ID_W-1:0]         winner_s;
  logic                    valid_s;
  logic                    grant_now_s;
  logic                    tmo_hit_s;
  logic [DATA_W*MAX_REQ-1:0] data_bus_s;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req    (req),
    .last   (last_r),
    .winner (winner_s),
    .valid  (valid_s)
  );

  assign data_bus_s  = (DATA_W*MAX_REQ)'(req_data);
  assign grant_now_s = (state_r == ST_IDLE) && arb_en && valid_s;
  assign tmo_hit_s   = (tmo_cnt_r == CNT_W'(BUSY_TIMEOUT - 1));

`ifdef UART_ARB_LOCK_EN
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  logic [BURST_W-1:0]      burst_cnt_r;
  logic [NUM_REQ-1:0]      grant_mask_s;
  logic                    relock_s;

  assign grant_mask_s = NUM_REQ'(1'b1) << grant_r;
  assign relock_s     = ((req & req_lock & grant_mask_s) != {NUM_REQ{1'b0}}) &&
                        (burst_cnt_r < BURST_W'(MAX_BURST));

  // Bytes sent in the current grant: restarts on every fresh round-robin grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_cnt_r <= {BURST_W{1'b0}};
    end else if (grant_now_s) begin
      burst_cnt_r <= BURST_W'(1);
    end else if ((state_r == ST_WAIT_DONE) && !Tx_BUSY && relock_s) begin
      burst_cnt_r <= burst_cnt_r + BURST_W'(1);
    end else begin
      burst_cnt_r <= burst_cnt_r;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^{req_lock, 32'(MAX_BURST)};
`endif

  // Arbitration FSM with all transmitter-facing outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      last_r    <= ID_W'(NUM_REQ - 1);
      grant_r   <= {ID_W{1'b0}};
      ack_r     <= {NUM_REQ{1'b0}};
      data_r    <= {DATA_W{1'b0}};
      wr_r      <= 1'b0;
      en_r      <= 1'b0;
      err_r     <= 1'b0;
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      ack_r <= {NUM_REQ{1'b0}};
      wr_r  <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_now_s) begin
            grant_r <= winner_s;
            data_r  <= lane_byte(data_bus_s, winner_s);
            ack_r   <= NUM_REQ'(1'b1) << winner_s;
            wr_r    <= 1'b1;
            en_r    <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            en_r    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          tmo_cnt_r <= {CNT_W{1'b0}};
          state_r   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (Tx_BUSY) begin
            state_r <= ST_WAIT_DONE;
          end else if (tmo_hit_s) begin
            // Transmitter never acknowledged the write: give up on this byte.
            err_r   <= 1'b1;
            last_r  <= grant_r;
            en_r    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!Tx_BUSY) begin
`ifdef UART_ARB_LOCK_EN
            if (relock_s) begin
              data_r  <= lane_byte(data_bus_s, grant_r);
              ack_r   <= grant_mask_s;
              wr_r    <= 1'b1;
              state_r <= ST_LOAD;
            end else begin
              last_r  <= grant_r;
              en_r    <= 1'b0;
              state_r <= ST_IDLE;
            end
`else
            last_r  <= grant_r;
            en_r    <= 1'b0;
            state_r <= ST_IDLE;
`endif
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        default: begin
          en_r    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack      = ack_r;
  assign grant_id = grant_r;
  assign err      = err_r;
  assign busy     = en_r;
  assign Tx_DATA  = data_r;
  assign Tx_WR    = wr_r;
  assign Tx_EN    = en_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as requests are
// issued and compared on every Tx_WR; a small transmitter model drives Tx_BUSY.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 15;
  localparam int MAX_BURST    = 3;
  localparam int TX_LEN       = 4;

  logic                 clk      = 1'b0;
  logic                 reset    = 1'b1;
  logic                 arb_en   = 1'b0;
  logic [NUM_REQ-1:0]   req      = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_lock = '0;
  logic                 Tx_BUSY  = 1'b0;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           grant_id;
  logic                 err;
  logic                 busy;
  logic [7:0]           Tx_DATA;
  logic                 Tx_WR;
  logic                 Tx_EN;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   rem[NUM_REQ];
  int   seq[NUM_REQ];
  logic [7:0] salt = 8'h00;
  bit   tx_stuck = 1'b0;
  int   tx_left = 0;
  int   cyc = 0;
  int   wr_cyc = 0;
  int   err_lat = 0;
  int   wr_count = 0;
  int   err_count = 0;
  int   vectors = 0;
  int   miscompares = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .MAX_BURST    (MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (arb_en),
    .req      (req),
    .req_data (req_data),
    .req_lock (req_lock),
    .ack      (ack),
    .grant_id (grant_id),
    .err      (err),
    .busy     (busy),
    .Tx_DATA  (Tx_DATA),
    .Tx_WR    (Tx_WR),
    .Tx_EN    (Tx_EN),
    .Tx_BUSY  (Tx_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int i, input int s);
    return ((8'(i) << 5) | 8'(s & 31)) ^ salt;
  endfunction

  function automatic void refresh();
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = (rem[i] > 0);
      req_data[8*i +: 8] = byte_of(i, seq[i]);
    end
  endfunction

  task automatic add_bytes(input int i, input int n);
    rem[i] = rem[i] + n;
    refresh();
  endtask

  task automatic push_exp(input int id, input int off);
    exp_t e;
    e.id   = 3'(id);
    e.data = byte_of(id, seq[id] + off);
    sb.push_back(e);
  endtask

  // One negedge step: scoreboard compare, requester update, transmitter model.
  task automatic monitor_step();
    exp_t e;
    if (Tx_WR) begin
      wr_count++;
      wr_cyc = cyc;
      if (sb.size() == 0) begin
        check_eq("spurious_wr", 32'(Tx_WR), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wr_id", 32'(grant_id), 32'(e.id));
        check_eq("wr_data", 32'(Tx_DATA), 32'(e.data));
        check_eq("wr_ack", 32'(ack), 32'd1 << e.id);
        check_eq("wr_en", 32'(Tx_EN), 32'd1);
      end
    end else if (ack != '0) begin
      check_eq("stray_ack", 32'(ack), 32'd0);
    end
    if (err) begin
      err_count++;
      err_lat = cyc - wr_cyc;
      if (!tx_stuck) check_eq("unexpected_err", 32'(err), 32'd0);
      else check_eq("err_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i] && rem[i] > 0) begin
        rem[i]--;
        seq[i]++;
      end
    end
    refresh();
    if (!reset) begin
      Tx_BUSY = 1'b0;
      tx_left = 0;
    end else if (Tx_WR && !tx_stuck) begin
      Tx_BUSY = 1'b1;
      tx_left = TX_LEN;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) Tx_BUSY = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy && !Tx_BUSY) ok = 1'b1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_tx_busy(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      if (Tx_BUSY && busy) ok = 1'b1;
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int e0;
    int w0;
    bit ok;
    fork
      forever begin @(posedge clk); cyc++; end
      forever begin @(negedge clk); monitor_step(); end
    join_none
    for (int i = 0; i < NUM_REQ; i++) begin
      rem[i] = 0;
      seq[i] = 0;
    end
    refresh();
    #2 reset = 1'b0;
    arb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wr", 32'(Tx_WR), 32'd0);
    check_eq("rst_en", 32'(Tx_EN), 32'd0);
    check_eq("rst_data", 32'(Tx_DATA), 32'd0);
    check_eq("rst_gid", 32'(grant_id), 32'd0);
    reset = 1'b1;

    // Single request: byte A5 from requester 0, one-cycle latency.
    salt = 8'hA5;
    push_exp(0, 0);
    add_bytes(0, 1);
    @(posedge clk); #1;
    check_eq("lat_wr", 32'(Tx_WR), 32'd1);
    check_eq("lat_ack", 32'(ack), 32'd1);
    wait_idle("single_done");
    check_eq("data_hold", 32'(Tx_DATA), 32'hA5);
    check_eq("busy_idle", 32'(busy), 32'd0);

    // Fairness from reset: 0,1,2,3,0.
    pulse_reset();
    salt = 8'h00;
    push_exp(0, 0); push_exp(1, 0); push_exp(2, 0); push_exp(3, 0); push_exp(0, 1);
    add_bytes(0, 2); add_bytes(1, 1); add_bytes(2, 1); add_bytes(3, 1);
    wait_idle("fair_done");

    // Timeout with Tx_BUSY stuck low, then rotation continues from last+1.
    tx_stuck = 1'b1;
    e0 = err_count;
    push_exp(1, 0);
    add_bytes(1, 1);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      if (err_count > e0) ok = 1'b1;
    end
    check_eq("err_seen", 32'(ok), 32'd1);
    check_eq("err_latency", 32'(err_lat), 32'(BUSY_TIMEOUT + 1));
    repeat (3) @(posedge clk);
    #1;
    check_eq("err_single", 32'(err_count - e0), 32'd1);
    check_eq("tmo_idle", 32'(busy), 32'd0);
    tx_stuck = 1'b0;
    push_exp(2, 0); push_exp(3, 0); push_exp(0, 0);
    add_bytes(0, 1); add_bytes(2, 1); add_bytes(3, 1);
    wait_idle("tmo_next_done");

    // Reset in WAIT_DONE: outputs clear without a clock edge.
    push_exp(1, 0);
    add_bytes(1, 1);
    wait_tx_busy("rst_mid_wait");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_eq("amid_busy", 32'(busy), 32'd0);
    check_eq("amid_en", 32'(Tx_EN), 32'd0);
    check_eq("amid_data", 32'(Tx_DATA), 32'd0);
    check_eq("amid_gid", 32'(grant_id), 32'd0);
    check_eq("amid_wr", 32'(Tx_WR), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    push_exp(0, 0); push_exp(3, 0);
    add_bytes(3, 1); add_bytes(0, 1);
    wait_idle("rst_prio_done");

    // arb_en low during WAIT_DONE: current byte finishes, no new grant.
    push_exp(1, 0);
    add_bytes(1, 1);
    wait_tx_busy("en_wait");
    @(posedge clk); #1;
    arb_en = 1'b0;
    push_exp(2, 0);
    add_bytes(2, 1);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #2;
      if (!busy && !Tx_BUSY) ok = 1'b1;
    end
    check_eq("en_byte_done", 32'(ok), 32'd1);
    w0 = wr_count;
    repeat (10) @(posedge clk);
    #1;
    check_eq("en_no_wr", 32'(wr_count), 32'(w0));
    check_eq("en_pending", 32'(sb.size()), 32'd1);
    check_eq("en_busy", 32'(busy), 32'd0);
    arb_en = 1'b1;
    wait_idle("en_resume_done");

`ifdef UART_ARB_LOCK_EN
    // Locked burst capped at MAX_BURST, then rotation.
    pulse_reset();
    salt = 8'h3C;
    req_lock = 4'b0001;
    push_exp(0, 0); push_exp(0, 1); push_exp(0, 2); push_exp(1, 0); push_exp(0, 3);
    add_bytes(0, 4); add_bytes(1, 1);
    wait_idle("lock_done");
    req_lock = 4'b0000;
`endif

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_transmitter` between `NUM_REQ` byte producers. It accepts one byte per grant from each requester and drives the transmitter's `Tx_DATA`, `Tx_WR` and `Tx_EN`. It then tracks `Tx_BUSY` to know when the shared line is free again. It sits between the system's byte sources and the single TX instance.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `BUSY_TIMEOUT`, 15: cycles to wait for `Tx_BUSY` to rise after `Tx_WR` before declaring an error.
- `MAX_BURST`, 16: maximum consecutive bytes per locked grant (lock feature only).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `arb_en`  in  1  arbitration enable; 0 blocks new grants but does not abort an active byte.
- `req`  in  `NUM_REQ`  requester i has a byte pending; held until `ack[i]`.
- `req_data`  in  `8*NUM_REQ`  byte of requester i at bits [8i+7:8i]; stable while `req[i]`.
- `req_lock`  in  `NUM_REQ`  requester i asks to keep the grant for the next byte (only with `UART_ARB_LOCK_EN`).
- `ack`  out  `NUM_REQ`  one-cycle pulse: byte of requester i captured.
- `grant_id`  out  3  index of the current or last granted requester.
- `err`  out  1  one-cycle pulse on `Tx_BUSY` timeout.
- `busy`  out  1  arbiter not in IDLE.
- `Tx_DATA`  out  8  byte to transmitter.
- `Tx_WR`  out  1  one-cycle write strobe to transmitter.
- `Tx_EN`  out  1  transmitter enable.
- `Tx_BUSY`  in  1  transmitter busy flag.

## Operation
- FSM states are IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
- **IDLE:**
  - If `arb_en` and any `req` is set, pick the winner by round-robin, searching from `last+1` modulo `NUM_REQ`.
  - Capture `req_data` of the winner into `Tx_DATA`, set `grant_id`, and move to LOAD.
- **LOAD:**
  - `Tx_WR`=1 and `ack[grant_id]`=1 for exactly this cycle.
  - Clear the timeout counter, then move to WAIT_BUSY.
- **WAIT_BUSY:**
  - `Tx_BUSY`=1 moves to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `BUSY_TIMEOUT`, pulse `err`, set `last`=`grant_id`, and return to IDLE.
- **WAIT_DONE:** `Tx_BUSY`=0 sets `last`=`grant_id` and returns to IDLE.
- `Tx_EN`=1 in every state except IDLE; `busy` has the same value as `Tx_EN`.
- `Tx_DATA` is held from IDLE→LOAD capture until the next capture.
- Only one `ack` bit is ever high at a time.
- Reset mid-operation returns to IDLE immediately. No `ack` or `err` pulse is emitted.
- A requester dropping `req` after its `ack` has no effect on the byte in flight.

## Timing
- Reset values:
  - `ack`=0, `err`=0, `busy`=0, `Tx_WR`=0, `Tx_EN`=0, `Tx_DATA`=0, `grant_id`=0.
  - `last`=`NUM_REQ-1`, so requester 0 wins first.
- Latency: `req` sampled high in IDLE at cycle n gives `Tx_WR` and `ack` at cycle n+1.
- The earliest next grant is the cycle after `Tx_BUSY` falls. It is sampled in IDLE, giving `Tx_WR` one cycle later.
- A requester may present a new byte on the cycle after its `ack`.
- `req` deasserted before it is sampled in IDLE is simply not granted.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In WAIT_DONE, when `Tx_BUSY` falls, if `req_lock[grant_id]` and `req[grant_id]` are both set and fewer than `MAX_BURST` bytes have been sent in the burst, the FSM goes directly to LOAD with the same requester. `req_data` is recaptured; `last` is not updated.
  - Reaching the `MAX_BURST` limit forces rotation.
  - A timeout ends the burst.
- `UART_ARB_LOCK_EN` undefined: `req_lock` is ignored; there is no burst counter and no lock logic.

## Structure
- Shared package `uart_pkg`: FSM state encoding and default widths.
- One sub-module: `rr_picker`, a combinational round-robin priority picker (`req`, `last` → `winner`, `valid`).
- The top level holds the FSM, the counters and the output registers.

## Test plan
- **Single request:** `req`=0001, `req_data[7:0]`=8'hA5 → `Tx_WR` and `ack[0]` one cycle later; `Tx_DATA`=8'hA5; `busy` falls after `Tx_BUSY` falls.
- **Fairness:** all four `req` held high → grant order 0,1,2,3,0, each with exactly one `ack` per byte.
- **Timeout:** `Tx_BUSY` tied 0 → `err` pulses `BUSY_TIMEOUT`+1 cycles after `Tx_WR`, FSM returns to IDLE, and the next grant goes to `last+1`.
- **Reset mid-transfer:** assert `reset`=0 in WAIT_DONE → all outputs are at reset values asynchronously; after release, requester 0 has priority.
- **`arb_en`=0 during WAIT_DONE:** the byte completes normally, and no new `Tx_WR` occurs until `arb_en`=1.
- **Lock burst (`UART_ARB_LOCK_EN`, `MAX_BURST`=3):** `req`=0011 and `req_lock[0]`=1 → bytes go to requester 0, 0, 0, then 1.
